cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 block, M stage of the 5-stage MIPS pipeline.
- Generator side of the exception/interrupt interface that the next-PC logic consumes:
  - produces the interrupt/exception request (npc forced to 0x0000_4180);
  - produces the saved return address (npc source on ERET).
- Holds SR, Cause, EPC and PRId; services mfc0/mtc0; latches exception state on the request cycle.

Parameters:
PRID_VAL, 32'h4255_4141, read-only value returned for PRId (reg 15)
HANDLER_ADDR, 32'h0000_4180, handler entry; must not appear in EPC on reset

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset)
A1  in  5  mfc0 read register number
A2  in  5  mtc0 write register number
DIn  in  32  mtc0 write data
we  in  1  mtc0 write enable (M-stage mtc0)
PC  in  32  M-stage instruction PC
BDIn  in  1  M-stage instruction is in a branch delay slot
ExcCodeIn  in  5  M-stage exception code, 0 = none
HWInt  in  6  external hardware interrupt lines, level-sensitive
EXLClr  in  1  eret committing in M stage
BadAddrIn  in  32  faulting data/instruction address (used only with optional feature)
IntReq  out  1  take exception/interrupt this cycle
EPCOut  out  32  current EPC register value
DOut  out  32  mfc0 read data

Behaviour:
- Registers and fields:
  - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC(14): 32 bits, bits[1:0] always 0.
  - PRId(15): constant PRID_VAL.
- Reset (reset==0 at edge): SR=0, Cause=0, EPC=0. Outputs follow: IntReq=0, EPCOut=0, DOut is a function of A1.
- Request logic (combinational, zero latency):
  - int_hit = |(HWInt & SR.IM) & SR.IE & !SR.EXL
  - exc_hit = (ExcCodeIn!=0) & !SR.EXL
  - IntReq = int_hit | exc_hit
  - Interrupt has priority over exception when both are present.
- On an edge with IntReq=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_hit ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00} (32-bit wrap on PC=0 with BD).
  - Any mtc0 (we) in the same cycle is discarded.
  - Any EXLClr in the same cycle is ignored (EXL ends at 1).
- Cause.IP <= HWInt every cycle, regardless of EXL, IE or we. Not writable.
- mtc0 (we=1, IntReq=0):
  - A2=12: IM, EXL, IE take DIn bits.
  - A2=14: EPC <= {DIn[31:2],2'b00}.
  - Cause, PRId and unimplemented numbers: write ignored.
- EXLClr=1 with IntReq=0: SR.EXL <= 0.
  - If we targets SR in the same cycle, the mtc0 value is written first, then EXL is forced to 0.
- mfc0 (DOut, combinational on A1): reg 12/13/14/15 return the register as stored; all other numbers return 0.
  - No write-to-read bypass: a read in the same cycle as a write returns the old value.
- EPCOut is the registered EPC. It updates the cycle after a capture or mtc0.
- Reset asserted in the same cycle as IntReq: reset wins; all state is 0.

Optional Feature:
Macro CP0_BADVADDR_EN.
- Defined:
  - Adds register BadVAddr(8), read-only through mfc0.
  - Loads BadAddrIn on an exception capture with ExcCode 4 (AdEL) or 5 (AdES) and int_hit=0.
  - Otherwise holds; reset value 0.
- Not defined:
  - BadAddrIn is unused.
  - mfc0 of reg 8 returns 0.

Test Plan:
- Reset, then read A1=12,13,14,15 -> 0, 0, 0, PRID_VAL. IntReq=0, EPCOut=0.
- mtc0 SR=0x0000_0401 (IM[10], IE). Drive HWInt=6'b000001 with PC=0x0000_3010, BDIn=0 -> IntReq=1 same cycle. Next cycle:
  - EPCOut=0x0000_3010;
  - Cause reads 0x0000_0400 (ExcCode 0);
  - SR reads 0x0000_0403;
  - IntReq=0 (EXL masks) while HWInt stays high.
- ExcCodeIn=10 (RI), PC=0x0000_3024, BDIn=1, SR.IE=0 -> IntReq=1. Next cycle:
  - EPCOut=0x0000_3020;
  - Cause reads 0x8000_0028.
- Same cycle: HWInt[2] enabled and ExcCodeIn=12 -> ExcCode latched as 0 (interrupt priority). Same cycle we=1, A2=14, DIn=0x1234 -> EPC not overwritten.
- With EXL=1, assert EXLClr and we=1, A2=12, DIn=0x0000_FC03 -> SR reads 0x0000_FC01. Pending enabled HWInt raises IntReq on the following cycle.
- CP0_BADVADDR_EN defined: ExcCodeIn=4, BadAddrIn=0x0000_0003 -> mfc0 A1=8 reads 0x0000_0003. Not defined -> reads 0.

Source files
------------

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 (SR, Cause, EPC, PRId) in the M stage; raises the exception/interrupt request.
//   Ports: clk, reset (sync, active-low); A1 mfc0 read index -> DOut; A2/DIn/we mtc0 write;
//          PC/BDIn/ExcCodeIn M-stage instruction info; HWInt level-sensitive interrupt lines;
//          EXLClr eret commit; BadAddrIn faulting address; IntReq request out; EPCOut saved return address.
//   Optional: define CP0_BADVADDR_EN to add read-only BadVAddr (reg 8), loaded on AdEL/AdES captures.
module cp0_unit #(
    parameter logic [31:0] PRID_VAL     = 32'h4255_4141,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        we,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    input  logic [31:0] BadAddrIn,
    output logic        IntReq,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);
    logic [5:0]  im_q, im_d, ip_q, ip_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d, sr_rd, cause_rd, bad_rd;
    logic        int_hit, exc_hit;
    logic        unused_ok;

    assign unused_ok = ^{PC[1:0], HANDLER_ADDR};

    always_comb begin
        int_hit = |(HWInt & im_q) & ie_q & ~exl_q;
        exc_hit = (ExcCodeIn != 5'd0) & ~exl_q;
        IntReq  = int_hit | exc_hit;
        im_d    = im_q;
        exl_d   = exl_q;
        ie_d    = ie_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        ip_d    = HWInt;
        if (IntReq) begin
            exl_d = 1'b1;
            exc_d = int_hit ? 5'd0 : ExcCodeIn;
            bd_d  = BDIn;
            epc_d = {PC[31:2], 2'b00} - (BDIn ? 32'd4 : 32'd0);
        end else begin
            if (we && A2 == 5'd12) begin
                im_d  = DIn[15:10];
                exl_d = DIn[1];
                ie_d  = DIn[0];
            end
            if (we && A2 == 5'd14)
                epc_d = {DIn[31:2], 2'b00};
            // eret wins over an mtc0 to SR in the same cycle
            if (EXLClr)
                exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] bad_q, bad_d;

    always_comb begin
        bad_d = bad_q;
        if (exc_hit && !int_hit && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5))
            bad_d = BadAddrIn;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            bad_q <= '0;
        else
            bad_q <= bad_d;
    end

    assign bad_rd = bad_q;
`else
    logic unused_bad;

    assign unused_bad = ^BadAddrIn;
    assign bad_rd     = 32'd0;
`endif

    assign sr_rd    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_rd = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
    assign EPCOut   = epc_q;
    assign DOut     = (A1 == 5'd12) ? sr_rd    :
                      (A1 == 5'd13) ? cause_rd :
                      (A1 == 5'd14) ? epc_q    :
                      (A1 == 5'd15) ? PRID_VAL :
                      (A1 == 5'd8)  ? bad_rd   : 32'd0;
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed-vector bench for cp0_unit with a word-level reference model and per-cycle compare.
module tb_cp0_unit;
    localparam logic [31:0] PRID = 32'h4255_4141;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] DIn, PC, BadAddrIn;
    logic        we, BDIn, EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPCOut, DOut;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0, m_bad = '0;
    logic        started = 1'b0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .we(we),
        .PC(PC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .BadAddrIn(BadAddrIn),
        .IntReq(IntReq), .EPCOut(EPCOut), .DOut(DOut)
    );

    always #5 clk = ~clk;

    function automatic logic m_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
`ifdef CP0_BADVADDR_EN
            5'd8:    return m_bad;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: architectural registers as whole words, updated from the rules.
    always @(posedge clk) begin
        automatic logic [31:0] sr = m_sr, cause = m_cause, epc = m_epc, bad = m_bad;
        automatic logic        ih = m_int(), rq = m_req();
        if (!reset) begin
            sr = 0; cause = 0; epc = 0; bad = 0;
        end else if (rq) begin
            sr    = sr | 32'h2;
            cause = (BDIn ? 32'h8000_0000 : 32'd0) + (32'(HWInt) << 10)
                  + (ih ? 32'd0 : 32'(ExcCodeIn) << 2);
            epc   = (PC & ~32'd3) - (BDIn ? 32'd4 : 32'd0);
            if (!ih && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) bad = BadAddrIn;
        end else begin
            if (we && A2 == 5'd12) sr = DIn & 32'h0000_FC03;
            if (we && A2 == 5'd14) epc = DIn & ~32'd3;
            if (EXLClr) sr = sr & ~32'h2;
            cause = (cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
        end
        m_sr    <= sr;
        m_cause <= cause;
        m_epc   <= epc;
        m_bad   <= bad;
        started <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("IntReq", 32'(IntReq), 32'(m_req()));
            chk("EPCOut", EPCOut, m_epc);
            chk("DOut", DOut, m_read(A1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(name, DOut, exp);
    endtask

    initial begin
        reset = 1'b0; A1 = 0; A2 = 0; DIn = 0; we = 0; PC = 0; BDIn = 0;
        ExcCodeIn = 0; HWInt = 0; EXLClr = 0; BadAddrIn = 0;
        tick();
        tick();
        reset = 1'b1;
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        rd("rst_prid", 5'd15, PRID);
        chk("rst_intreq", 32'(IntReq), 32'd0);
        chk("rst_epcout", EPCOut, 32'd0);
        // interrupt on HWInt[0]
        we = 1; A2 = 12; DIn = 32'h0000_0401;
        tick();
        we = 0; HWInt = 6'b000001; PC = 32'h0000_3010; BDIn = 0;
        #1;
        chk("int_req", 32'(IntReq), 32'd1);
        tick();
        chk("int_epc", EPCOut, 32'h0000_3010);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr", 5'd12, 32'h0000_0403);
        chk("int_masked", 32'(IntReq), 32'd0);
        // clear EXL and SR, then RI exception in delay slot
        EXLClr = 1; we = 1; A2 = 12; DIn = 0;
        tick();
        EXLClr = 0; we = 0; HWInt = 0;
        ExcCodeIn = 5'd10; PC = 32'h0000_3024; BDIn = 1;
        #1;
        chk("exc_req", 32'(IntReq), 32'd1);
        tick();
        ExcCodeIn = 0; BDIn = 0;
        chk("exc_epc", EPCOut, 32'h0000_3020);
        rd("exc_cause", 5'd13, 32'h8000_0028);
        // interrupt beats exception; same-cycle mtc0 to EPC dropped
        EXLClr = 1; we = 1; A2 = 12; DIn = 32'h0000_1001;
        tick();
        EXLClr = 0; HWInt = 6'b000100; ExcCodeIn = 5'd12;
        we = 1; A2 = 14; DIn = 32'h0000_1234; PC = 32'h0000_3040;
        #1;
        chk("prio_req", 32'(IntReq), 32'd1);
        tick();
        we = 0; ExcCodeIn = 0;
        chk("prio_epc", EPCOut, 32'h0000_3040);
        rd("prio_cause", 5'd13, 32'h0000_1000);
        // eret with mtc0 SR in the same cycle; no read bypass
        EXLClr = 1; we = 1; A2 = 12; DIn = 32'h0000_FC03;
        rd("nobypass_sr", 5'd12, 32'h0000_1003);
        chk("eret_req", 32'(IntReq), 32'd0);
        tick();
        EXLClr = 0; we = 0;
        rd("eret_sr", 5'd12, 32'h0000_FC01);
        chk("pend_req", 32'(IntReq), 32'd1);
        PC = 32'h0000_3050;
        tick();
        // AdEL in delay slot at PC=0: EPC wraps
        EXLClr = 1; HWInt = 0;
        tick();
        EXLClr = 0; ExcCodeIn = 5'd4; BadAddrIn = 32'h0000_0003; PC = 0; BDIn = 1;
        tick();
        ExcCodeIn = 0; BDIn = 0;
        chk("wrap_epc", EPCOut, 32'hFFFF_FFFC);
`ifdef CP0_BADVADDR_EN
        rd("badvaddr", 5'd8, 32'h0000_0003);
`else
        rd("badvaddr", 5'd8, 32'd0);
`endif
        // ignored writes and EPC alignment
        EXLClr = 1;
        tick();
        EXLClr = 0; we = 1; A2 = 13; DIn = 32'hFFFF_FFFF;
        tick();
        A2 = 15;
        tick();
        A2 = 14; DIn = 32'h0001_2347;
        tick();
        we = 0;
        chk("epc_align", EPCOut, 32'h0001_2344);
        rd("cause_ro", 5'd13, 32'h8000_0010);
        rd("unimpl", 5'd3, 32'd0);
        // reset beats a simultaneous request
        ExcCodeIn = 5'd8; reset = 0;
        tick();
        reset = 1; ExcCodeIn = 0;
        chk("rst_req_epc", EPCOut, 32'd0);
        rd("rst_req_sr", 5'd12, 32'd0);
        rd("rst_req_cause", 5'd13, 32'd0);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
